// File: rtl/usb_reset_pkg.sv
// Shared encodings for the host-side USB bus-reset / speed negotiator.
// Holds speed codes, UTMI line-state, OpMode and XcvrSelect constants, chirp data and the FSM state type.
// Optional macro USB_RESET_LS_DETECT_EN adds the LS_PROBE state.
package usb_reset_pkg;

    localparam logic [1:0] SPEED_UNKNOWN = 2'b00;
    localparam logic [1:0] SPEED_FS      = 2'b01;
    localparam logic [1:0] SPEED_HS      = 2'b10;
    localparam logic [1:0] SPEED_LS      = 2'b11;

    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_J   = 2'b01;
    localparam logic [1:0] LINE_K   = 2'b10;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    // OpMode 10 disables bit stuffing and NRZI so SE0 and raw chirp bytes reach the wire.
    localparam logic [1:0] OPMODE_NORMAL = 2'b00;
    localparam logic [1:0] OPMODE_CHIRP  = 2'b10;

    localparam logic [1:0] XCVR_HS = 2'b00;
    localparam logic [1:0] XCVR_FS = 2'b01;
    localparam logic [1:0] XCVR_LS = 2'b10;

    localparam logic [7:0] CHIRP_K = 8'h00;
    localparam logic [7:0] CHIRP_J = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        SE0,
        WAIT_KEND,
        HCHIRP,
        DONE_HS,
        DONE_FS
`ifdef USB_RESET_LS_DETECT_EN
        ,
        LS_PROBE
`endif
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_linestate_filter.sv
// Run-length detector: match_o is high in the Nth consecutive cycle where line_state_i == target_i while enabled.
// Latency: combinational match on the Nth sample; counter registered. No backpressure.
// Ports: clk/rst_n, line_state_i, target_i, enable_i in; match_o out.
module usb_linestate_filter #(
    parameter int N = 150,
    parameter int W = $clog2(N) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] line_state_i,
    input  logic [1:0] target_i,
    input  logic       enable_i,
    output logic       match_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic         hit;
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign hit = enable_i && (line_state_i == target_i);

    // Any non-target cycle (or disable) restarts the run; saturate so a long run keeps matching.
    always_comb begin
        cnt_d = '0;
        if (hit) begin
            cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_o = hit && (cnt_q == LAST);

endmodule

// File: rtl/usb_reset_negotiator.sv
// Host bus-reset controller: drives SE0, detects device Chirp K, answers with K/J chirp train, settles HS or FS.
// Latency: request to reset_done is RESET_CYCLES+1 cycles (RESET_CYCLES+17 with USB_RESET_LS_DETECT_EN).
// Backpressure: chirp beats only advance on cycles with utmi_tx_ready; the master timer never stalls.
// Ports: link side bus_reset_req/hs_allow in, reset_active/reset_done/detected_speed/chirp_fail out;
//        UTMI side phy_op_mode/phy_xcvr_select/phy_term_select/utmi_tx_* out, phy_line_state/utmi_tx_ready in.
module usb_reset_negotiator
    import usb_reset_pkg::*;
#(
    parameter int RESET_CYCLES      = 600000,
    parameter int CHIRP_K_MIN       = 150,
    parameter int DEV_CHIRP_TIMEOUT = 420000,
    parameter int CHIRP_BEAT        = 3000,
    parameter int MIN_KJ_PAIRS      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bus_reset_req,
    input  logic       hs_allow,
    output logic       reset_active,
    output logic       reset_done,
    output logic [1:0] detected_speed,
    output logic       chirp_fail,
    output logic [1:0] phy_op_mode,
    output logic [1:0] phy_xcvr_select,
    output logic       phy_term_select,
    input  logic [1:0] phy_line_state,
    output logic [7:0] utmi_tx_data,
    output logic       utmi_tx_valid,
    input  logic       utmi_tx_ready
);

    localparam int MAX_P = max_int(max_int(max_int(RESET_CYCLES, CHIRP_K_MIN),
                                           max_int(DEV_CHIRP_TIMEOUT, CHIRP_BEAT)),
                                   MIN_KJ_PAIRS);
    localparam int CW = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] TMR_LAST  = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] CHIRP_TMO = CW'(DEV_CHIRP_TIMEOUT);
    localparam logic [CW-1:0] BEAT_LAST = CW'(CHIRP_BEAT - 1);
    localparam logic [CW-1:0] PAIRS_MIN = CW'(MIN_KJ_PAIRS);

    // Every Full-Speed outcome leaves through FS_EXIT so the optional LS probe slots in uniformly.
`ifdef USB_RESET_LS_DETECT_EN
    localparam state_e FS_EXIT = LS_PROBE;
`else
    localparam state_e FS_EXIT = DONE_FS;
`endif

    state_e          state_q, state_d;
    logic [CW-1:0]   tmr_q, tmr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            beat_j_q, beat_j_d;
    logic [CW-1:0]   pairs_q, pairs_d;
    logic            hs_allow_q, hs_allow_d;
    logic            se1_prev_q, se1_prev_d;
    logic [1:0]      speed_q, speed_d;
    logic            chirp_fail_q, chirp_fail_d;

    logic            in_reset;
    logic            tmr_expired;
    logic            se1_abort;
    logic            k_match;

    usb_linestate_filter #(
        .N (CHIRP_K_MIN),
        .W (CW)
    ) u_chirp_k_filt (
        .clk          (clk),
        .rst_n        (rst_n),
        .line_state_i (phy_line_state),
        .target_i     (LINE_K),
        .enable_i     (state_q == SE0),
        .match_o      (k_match)
    );

`ifdef USB_RESET_LS_DETECT_EN
    logic [3:0] probe_cnt_q, probe_cnt_d;
    logic       ls_match;

    // LS devices idle with D- high, which reads as K on a FS-configured transceiver.
    usb_linestate_filter #(
        .N (16),
        .W (5)
    ) u_ls_probe_filt (
        .clk          (clk),
        .rst_n        (rst_n),
        .line_state_i (phy_line_state),
        .target_i     (LINE_K),
        .enable_i     (state_q == LS_PROBE),
        .match_o      (ls_match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe_cnt_q <= '0;
        end else begin
            probe_cnt_q <= probe_cnt_d;
        end
    end
`endif

    always_comb begin
        in_reset = 1'b0;
        unique case (state_q)
            SE0, WAIT_KEND, HCHIRP: in_reset = 1'b1;
`ifdef USB_RESET_LS_DETECT_EN
            LS_PROBE:               in_reset = 1'b1;
`endif
            default:                in_reset = 1'b0;
        endcase
    end

    assign tmr_expired = (tmr_q == TMR_LAST);
    // se1_prev_q only records SE1 seen in an active state, so two in a row means a genuine SE1 run.
    assign se1_abort   = (phy_line_state == LINE_SE1) && se1_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tmr_q        <= '0;
            beat_cnt_q   <= '0;
            beat_j_q     <= 1'b0;
            pairs_q      <= '0;
            hs_allow_q   <= 1'b0;
            se1_prev_q   <= 1'b0;
            speed_q      <= SPEED_UNKNOWN;
            chirp_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            beat_cnt_q   <= beat_cnt_d;
            beat_j_q     <= beat_j_d;
            pairs_q      <= pairs_d;
            hs_allow_q   <= hs_allow_d;
            se1_prev_q   <= se1_prev_d;
            speed_q      <= speed_d;
            chirp_fail_q <= chirp_fail_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        beat_cnt_d   = beat_cnt_q;
        beat_j_d     = beat_j_q;
        pairs_d      = pairs_q;
        hs_allow_d   = hs_allow_q;
        se1_prev_d   = 1'b0;
        speed_d      = speed_q;
        chirp_fail_d = chirp_fail_q;
`ifdef USB_RESET_LS_DETECT_EN
        probe_cnt_d  = probe_cnt_q;
`endif

        // Master timer runs from SE0 entry to completion and is never restarted mid-reset.
        if (in_reset) begin
            tmr_d      = tmr_q + 1'b1;
            se1_prev_d = (phy_line_state == LINE_SE1);
        end

        unique case (state_q)
            IDLE: begin
                if (bus_reset_req) begin
                    hs_allow_d   = hs_allow;
                    chirp_fail_d = 1'b0;
                    speed_d      = SPEED_UNKNOWN;
                    tmr_d        = '0;
                    beat_cnt_d   = '0;
                    beat_j_d     = 1'b0;
                    pairs_d      = '0;
                    state_d      = SE0;
                end
            end
            SE0: begin
                if (se1_abort) begin
                    state_d      = FS_EXIT;
                    speed_d      = SPEED_FS;
                    chirp_fail_d = 1'b1;
                end else if (tmr_expired) begin
                    state_d = FS_EXIT;
                    speed_d = SPEED_FS;
                end else if (k_match && (tmr_q < CHIRP_TMO) && hs_allow_q) begin
                    state_d = WAIT_KEND;
                end
            end
            WAIT_KEND: begin
                if (se1_abort || tmr_expired) begin
                    state_d      = FS_EXIT;
                    speed_d      = SPEED_FS;
                    chirp_fail_d = 1'b1;
                end else if (phy_line_state != LINE_K) begin
                    state_d = HCHIRP;
                end
            end
            HCHIRP: begin
                if (utmi_tx_ready) begin
                    if (beat_cnt_q == BEAT_LAST) begin
                        beat_cnt_d = '0;
                        beat_j_d   = ~beat_j_q;
                        // A pair completes when a J beat ends.
                        if (beat_j_q && (pairs_q != '1)) begin
                            pairs_d = pairs_q + 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
                if (se1_abort) begin
                    state_d      = FS_EXIT;
                    speed_d      = SPEED_FS;
                    chirp_fail_d = 1'b1;
                end else if (tmr_expired) begin
                    if (pairs_q >= PAIRS_MIN) begin
                        state_d = DONE_HS;
                        speed_d = SPEED_HS;
                    end else begin
                        state_d      = FS_EXIT;
                        speed_d      = SPEED_FS;
                        chirp_fail_d = 1'b1;
                    end
                end
            end
`ifdef USB_RESET_LS_DETECT_EN
            LS_PROBE: begin
                probe_cnt_d = probe_cnt_q + 1'b1;
                if (se1_abort) begin
                    state_d      = DONE_FS;
                    chirp_fail_d = 1'b1;
                end else if (probe_cnt_q == 4'd15) begin
                    state_d = DONE_FS;
                    if (ls_match) begin
                        speed_d = SPEED_LS;
                    end
                end
            end
`endif
            DONE_HS, DONE_FS: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore output decode; IDLE keeps the transceiver in the configuration of the last outcome.
    always_comb begin
        reset_done      = 1'b0;
        phy_op_mode     = OPMODE_NORMAL;
        phy_xcvr_select = XCVR_FS;
        phy_term_select = 1'b1;
        utmi_tx_data    = CHIRP_K;
        utmi_tx_valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (speed_q == SPEED_HS) begin
                    phy_xcvr_select = XCVR_HS;
                    phy_term_select = 1'b0;
                end else if (speed_q == SPEED_LS) begin
                    phy_xcvr_select = XCVR_LS;
                end
            end
            SE0, WAIT_KEND: begin
                phy_op_mode     = OPMODE_CHIRP;
                phy_xcvr_select = XCVR_HS;
                phy_term_select = 1'b0;
            end
            HCHIRP: begin
                phy_op_mode     = OPMODE_CHIRP;
                phy_xcvr_select = XCVR_HS;
                phy_term_select = 1'b0;
                utmi_tx_valid   = 1'b1;
                utmi_tx_data    = beat_j_q ? CHIRP_J : CHIRP_K;
            end
            DONE_HS: begin
                phy_xcvr_select = XCVR_HS;
                phy_term_select = 1'b0;
                reset_done      = 1'b1;
            end
            DONE_FS: begin
                phy_xcvr_select = (speed_q == SPEED_LS) ? XCVR_LS : XCVR_FS;
                reset_done      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign reset_active   = in_reset;
    assign detected_speed = speed_q;
    assign chirp_fail     = chirp_fail_q;

endmodule

// File: tb/tb_usb_reset_negotiator.sv
// Directed bench for usb_reset_negotiator with shortened timing parameters.
// Cycle 0 is the cycle bus_reset_req is high; cycle c is sampled 1 time unit after the c-th following edge.
module tb_usb_reset_negotiator;

    localparam int RC    = 2000;
    localparam int KMIN  = 60;
    localparam int TMO   = 1400;
    localparam int BEAT  = 50;
    localparam int PAIRS = 3;

    localparam logic [1:0] LK = 2'b10;
    localparam logic [1:0] LJ = 2'b01;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bus_reset_req = 1'b0;
    logic       hs_allow = 1'b0;
    logic [1:0] phy_line_state = 2'b01;
    logic       utmi_tx_ready = 1'b0;
    logic       reset_active;
    logic       reset_done;
    logic [1:0] detected_speed;
    logic       chirp_fail;
    logic [1:0] phy_op_mode;
    logic [1:0] phy_xcvr_select;
    logic       phy_term_select;
    logic [7:0] utmi_tx_data;
    logic       utmi_tx_valid;

    always #5 clk = ~clk;

    usb_reset_negotiator #(
        .RESET_CYCLES      (RC),
        .CHIRP_K_MIN       (KMIN),
        .DEV_CHIRP_TIMEOUT (TMO),
        .CHIRP_BEAT        (BEAT),
        .MIN_KJ_PAIRS      (PAIRS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus_reset_req   (bus_reset_req),
        .hs_allow        (hs_allow),
        .reset_active    (reset_active),
        .reset_done      (reset_done),
        .detected_speed  (detected_speed),
        .chirp_fail      (chirp_fail),
        .phy_op_mode     (phy_op_mode),
        .phy_xcvr_select (phy_xcvr_select),
        .phy_term_select (phy_term_select),
        .phy_line_state  (phy_line_state),
        .utmi_tx_data    (utmi_tx_data),
        .utmi_tx_valid   (utmi_tx_valid),
        .utmi_tx_ready   (utmi_tx_ready)
    );

    int checks = 0;
    int errors = 0;

    // Per-run observations
    int         done_cyc, act_cnt, vld_cnt, first_vld, data_bad, op_bad;
    logic [7:0] last_data;
    logic [1:0] c1_speed, d_speed, d_op, d_xcvr, post_speed, post_xcvr;
    logic       c1_fail, d_fail, d_term, d_vld, d_act, post_done, post_act, post_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request, then script line state as K in [k1s,k1e) and [k2s,k2e), J otherwise.
    task automatic run(input int k1s, input int k1e, input int k2s, input int k2e,
                       input int rdy_until, input int rereq_at);
        logic [7:0] exp_dat;
        done_cyc  = -1;
        act_cnt   = 0;
        vld_cnt   = 0;
        first_vld = -1;
        data_bad  = 0;
        op_bad    = 0;
        last_data = 8'h5A;
        bus_reset_req  = 1'b1;
        phy_line_state = LJ;
        utmi_tx_ready  = 1'b1;
        tick();
        bus_reset_req = 1'b0;
        for (int c = 1; c <= RC + 100; c++) begin
            phy_line_state = ((c >= k1s && c < k1e) || (c >= k2s && c < k2e)) ? LK : LJ;
            utmi_tx_ready  = (c <= rdy_until);
            bus_reset_req  = (c == rereq_at);
            if (c == 1) begin
                c1_speed = detected_speed;
                c1_fail  = chirp_fail;
            end
            if (reset_active) begin
                act_cnt++;
                if (phy_op_mode !== 2'b10 || phy_xcvr_select !== 2'b00 || phy_term_select !== 1'b0)
                    op_bad++;
            end
            if (utmi_tx_valid) begin
                vld_cnt++;
                if (first_vld < 0) first_vld = c;
                exp_dat = ((((c - first_vld) / BEAT) % 2) == 1) ? 8'hFF : 8'h00;
                if (utmi_tx_data !== exp_dat) data_bad++;
                last_data = utmi_tx_data;
            end
            if (reset_done) begin
                done_cyc = c;
                d_speed  = detected_speed;
                d_op     = phy_op_mode;
                d_xcvr   = phy_xcvr_select;
                d_fail   = chirp_fail;
                d_term   = phy_term_select;
                d_vld    = utmi_tx_valid;
                d_act    = reset_active;
                break;
            end
            tick();
        end
        bus_reset_req  = 1'b0;
        phy_line_state = LJ;
        tick();
        post_done  = reset_done;
        post_act   = reset_active;
        post_speed = detected_speed;
        post_xcvr  = phy_xcvr_select;
        post_fail  = chirp_fail;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_active"}, reset_active, 1'b0);
        chk({pfx, "_done"},   reset_done, 1'b0);
        chk({pfx, "_speed"},  detected_speed, 2'b00);
        chk({pfx, "_fail"},   chirp_fail, 1'b0);
        chk({pfx, "_op"},     phy_op_mode, 2'b00);
        chk({pfx, "_xcvr"},   phy_xcvr_select, 2'b01);
        chk({pfx, "_term"},   phy_term_select, 1'b1);
        chk({pfx, "_txdat"},  utmi_tx_data, 8'h00);
        chk({pfx, "_txvld"},  utmi_tx_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        chk_reset_vals("por");
        rst_n = 1'b1;
        tick();

        // Line idle J, no device chirp: plain FS reset
        hs_allow = 1'b1;
        run(0, 0, 0, 0, 100000, 0);
        chk("fs_done_cyc",  done_cyc, 2001);
        chk("fs_act_cnt",   act_cnt, 2000);
        chk("fs_op_during", op_bad, 0);
        chk("fs_no_tx",     vld_cnt, 0);
        chk("fs_speed",     d_speed, 2'b01);
        chk("fs_fail",      d_fail, 1'b0);
        chk("fs_act_done",  d_act, 1'b0);
        chk("fs_xcvr",      d_xcvr, 2'b01);
        chk("fs_term",      d_term, 1'b1);
        chk("fs_pulse_len", post_done, 1'b0);
        chk("fs_idle_spd",  post_speed, 2'b01);

        // Device chirp K cycles 100..299: accepted at 159, K ends at 300, host chirp from 301
        run(100, 300, 0, 0, 100000, 0);
        chk("hs_first_vld", first_vld, 301);
        chk("hs_vld_cnt",   vld_cnt, 1700);
        chk("hs_kj_data",   data_bad, 0);
        chk("hs_done_cyc",  done_cyc, 2001);
        chk("hs_speed",     d_speed, 2'b10);
        chk("hs_xcvr",      d_xcvr, 2'b00);
        chk("hs_term",      d_term, 1'b0);
        chk("hs_op",        d_op, 2'b00);
        chk("hs_vld_done",  d_vld, 1'b0);
        chk("hs_fail",      d_fail, 1'b0);
        chk("hs_idle_xcvr", post_xcvr, 2'b00);

        // Same chirp with HS disallowed
        hs_allow = 1'b0;
        run(100, 300, 0, 0, 100000, 0);
        chk("nohs_c1_speed", c1_speed, 2'b00);
        chk("nohs_no_tx",    vld_cnt, 0);
        chk("nohs_speed",    d_speed, 2'b01);
        chk("nohs_done_cyc", done_cyc, 2001);

        // 40-cycle K too short, late K at 1500 past the chirp window
        hs_allow = 1'b1;
        run(100, 140, 1500, 1800, 100000, 0);
        chk("rej_no_tx",    vld_cnt, 0);
        chk("rej_speed",    d_speed, 2'b01);
        chk("rej_fail",     d_fail, 1'b0);
        chk("rej_done_cyc", done_cyc, 2001);

        // Chirp accepted, PHY stalls after the first K beat: no pairs complete
        run(100, 300, 0, 0, 350, 0);
        chk("stall_first_vld", first_vld, 301);
        chk("stall_last_dat",  last_data, 8'hFF);
        chk("stall_speed",     d_speed, 2'b01);
        chk("stall_fail",      d_fail, 1'b1);
        chk("stall_xcvr",      d_xcvr, 2'b01);
        chk("stall_done_cyc",  done_cyc, 2001);
        chk("stall_sticky",    post_fail, 1'b1);

        // Re-request during an active reset must not restart it; chirp_fail clears on request
        run(0, 0, 0, 0, 100000, 700);
        chk("rereq_c1_fail",  c1_fail, 1'b0);
        chk("rereq_done_cyc", done_cyc, 2001);
        chk("rereq_idle_act", post_act, 1'b0);

        // Asynchronous reset at cycle 500 while sending a J beat
        bus_reset_req  = 1'b1;
        phy_line_state = LJ;
        utmi_tx_ready  = 1'b1;
        tick();
        bus_reset_req = 1'b0;
        for (int c = 1; c < 500; c++) begin
            phy_line_state = (c >= 100 && c < 300) ? LK : LJ;
            tick();
        end
        chk("arst_pre_vld", utmi_tx_valid, 1'b1);
        chk("arst_pre_dat", utmi_tx_data, 8'hFF);
        chk("arst_pre_act", reset_active, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        tick();
        rst_n = 1'b1;
        tick();
        run(0, 0, 0, 0, 100000, 0);
        chk("after_arst_done", done_cyc, 2001);
        chk("after_arst_spd",  d_speed, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_reset_negotiator.md
Name: usb_reset_negotiator

Overview:
Parametrised successor to the host-side USB bus-reset controller. Drives bus reset (SE0) for a programmable duration and detects a device Chirp K with a debounce filter. When HS is allowed and a chirp is seen, it answers with a host K/J chirp train and settles at High-Speed; otherwise it settles at Full-Speed. Sits between the host link layer and the UTMI PHY control/transmit pins.

Parameters:
RESET_CYCLES, 600000, total reset duration in clk cycles (10 ms at 60 MHz)
CHIRP_K_MIN, 150, consecutive K cycles needed to accept the device chirp (2.5 us)
DEV_CHIRP_TIMEOUT, 420000, cycles after reset start by which the device chirp must have begun (7 ms)
CHIRP_BEAT, 3000, cycles per host K or J beat (50 us)
MIN_KJ_PAIRS, 3, minimum host K/J pairs required before HS is declared

Ports:
clk  in  1  60 MHz UTMI clock
rst_n  in  1  asynchronous active-low reset
bus_reset_req  in  1  single-cycle request to start a reset
hs_allow  in  1  0 forces FS result (sampled at request)
reset_active  out  1  high from the cycle after the request until completion
reset_done  out  1  one-cycle pulse on completion
detected_speed  out  2  00 unknown, 01 FS, 10 HS, 11 LS
chirp_fail  out  1  sticky: device chirp seen but fewer than MIN_KJ_PAIRS completed; cleared on next request
phy_op_mode  out  2  UTMI OpMode
phy_xcvr_select  out  2  UTMI XcvrSelect
phy_term_select  out  1  UTMI TermSelect
phy_line_state  in  2  00 SE0, 01 J, 10 K, 11 SE1
utmi_tx_data  out  8  chirp data
utmi_tx_valid  out  1  chirp valid
utmi_tx_ready  in  1  PHY accepts data

Behaviour:
- Reset values: reset_active 0, reset_done 0, detected_speed 00, chirp_fail 0, op_mode 00, xcvr 01, term 1, tx_data 00, tx_valid 0. State IDLE. All counters 0.
- Counter widths are $clog2 of the largest parameter plus 1. One master timer (rst_tmr) counts every cycle from entry to SE0 and never restarts inside one reset.
- IDLE: on bus_reset_req, latch hs_allow, clear chirp_fail, set detected_speed 00, go to SE0. reset_active rises on the next edge.
- SE0 state:
  - op_mode 10, xcvr 00, term 0, tx_valid 0.
  - Filter counter increments while line_state==K and zeroes otherwise.
  - When the filter reaches CHIRP_K_MIN, rst_tmr < DEV_CHIRP_TIMEOUT and latched hs_allow is 1: go to WAIT_KEND.
  - When rst_tmr reaches RESET_CYCLES-1: go to DONE_FS.
- WAIT_KEND: hold SE0 config until line_state != K, then go to HCHIRP. If rst_tmr expires first, go to DONE_FS with chirp_fail=1.
- HCHIRP:
  - op_mode 10, xcvr 00, term 0, tx_valid 1.
  - tx_data is 0x00 for a K beat and 0xFF for a J beat, starting with K.
  - The beat counter advances only on cycles where tx_ready=1. The beat toggles when the counter hits CHIRP_BEAT-1.
  - The pair counter increments at the end of each J beat.
  - On rst_tmr expiry: go to DONE_HS if pairs >= MIN_KJ_PAIRS, else DONE_FS with chirp_fail=1.
- DONE_HS: op_mode 00, xcvr 00, term 0, detected_speed 10. DONE_FS: op_mode 00, xcvr 01, term 1, detected_speed 01.
  - Both: tx_valid 0 in the same cycle, reset_done pulses one cycle, reset_active falls, return to IDLE.
- Total latency from request to reset_done is exactly RESET_CYCLES+1 cycles.
- bus_reset_req while reset_active is ignored (no restart).
- line_state SE1 for 2 or more consecutive cycles in any active state: abort to DONE_FS with chirp_fail=1.
- rst_n asserted mid-operation: all outputs return to reset values immediately (asynchronous).
- A K that lasts shorter than CHIRP_K_MIN is ignored and the filter restarts.

Optional Feature:
- Macro USB_RESET_LS_DETECT_EN.
- When defined, DONE_FS is followed by a 16-cycle LS_PROBE. If line_state==K (LS idle polarity) for all 16 cycles, detected_speed is 11 and xcvr is 10; otherwise 01.
  - reset_done and the reset_active fall are delayed to the end of the probe, so latency is RESET_CYCLES+17.
- When not defined, LS_PROBE does not exist and detected_speed is never 11.

Decomposition:
- Package usb_reset_pkg holds:
  - speed encodings (SPEED_UNKNOWN/FS/HS/LS);
  - line-state constants;
  - OpMode and XcvrSelect constants;
  - chirp data constants CHIRP_K=0x00, CHIRP_J=0xFF;
  - the state enum.
- Sub-module usb_linestate_filter: parametrised run-length detector with inputs line_state, target and enable, output match after N consecutive cycles. It is used for the device-chirp K detection and the LS probe.

Test Plan (RESET_CYCLES=2000, CHIRP_K_MIN=60, DEV_CHIRP_TIMEOUT=1400, CHIRP_BEAT=50, MIN_KJ_PAIRS=3):
- Line held J, request -> reset_active high for 2000 cycles, op_mode 10 during reset, reset_done pulse at cycle 2001, speed 01, chirp_fail 0.
- Device K from cycle 100 to 300, tx_ready=1 -> tx_data first 0x00 then 0xFF, toggling every 50 cycles; speed 10, xcvr 00, term 0.
- Same but hs_allow=0 -> no tx_valid, speed 01.
- K lasting 40 cycles, then K at cycle 1500 -> both rejected, speed 01, chirp_fail 0.
- Device K accepted, tx_ready held 0 after the first beat -> fewer than 3 pairs, speed 01, chirp_fail 1.
- rst_n low at cycle 500 of an active reset -> all outputs at reset values in that cycle; a new request afterwards completes normally. Also assert that a second request during an active reset leaves the completion cycle unchanged.
